// File: rtl/dec_3_to_8.sv
// Registered binary-to-one-hot (or one-cold) decoder with enable.
// Latency: 1 clk from d_in/e to d_out; d_out is a pure register output.
// Backpressure: none; a new select code is accepted every cycle.
module dec_3_to_8 #(
  parameter int IN_W       = 3,
  parameter int OUT_W      = 1 << IN_W,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  d_in,
  input  logic             e,
  output logic [OUT_W-1:0] d_out
);

  // Value held while no bit is selected (reset, disabled, out-of-range code).
  localparam logic [OUT_W-1:0] IDLE_VAL = {OUT_W{ACTIVE_LOW}};

  logic [OUT_W-1:0] hot;
  logic [OUT_W-1:0] dec_d;
  logic [OUT_W-1:0] dec_q;

  // One-hot decode over the full select width; codes >= OUT_W match no bit.
  always_comb begin
    hot = '0;
    for (int k = 0; k < OUT_W; k++) begin
      hot[k] = e && (32'(d_in) == k);
    end
    dec_d = ACTIVE_LOW ? ~hot : hot;
  end

  // Output register; reset drives the inactive value immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q <= IDLE_VAL;
    end else begin
      dec_q <= dec_d;
    end
  end

  assign d_out = dec_q;

endmodule

// File: tb/tb_dec_3_to_8.sv
// Bench for dec_3_to_8: default 3->8 decoder plus two 3->6 variants
// (active-high and active-low) driven from the same select/enable.
// Directed steps followed by a randomized run against a reference model.
module tb_dec_3_to_8;

  logic       clk;
  logic       rst;
  logic [2:0] d_in;
  logic       e;
  logic [7:0] d_out;
  logic [5:0] d_out_al;
  logic [5:0] d_out_ah;

  int n_tests = 0;
  int n_fail  = 0;

  dec_3_to_8 dut (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in),
    .e    (e),
    .d_out(d_out)
  );

  dec_3_to_8 #(.IN_W(3), .OUT_W(6), .ACTIVE_LOW(1'b1)) dut_al (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in),
    .e    (e),
    .d_out(d_out_al)
  );

  dec_3_to_8 #(.IN_W(3), .OUT_W(6), .ACTIVE_LOW(1'b0)) dut_ah (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in),
    .e    (e),
    .d_out(d_out_ah)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: selected bit = 1 << code when enabled and in range, else none;
  // active-low inverts within the output width.
  function automatic logic [7:0] model(input int w, input bit al, input int din, input bit en);
    logic [7:0] mask;
    logic [7:0] r;
    mask = 8'((1 << w) - 1);
    r    = (en && din < w) ? 8'(1 << din) : 8'h00;
    if (al) r = ~r & mask;
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int din, input bit en);
    check({tag, "/main"}, d_out, model(8, 1'b0, din, en));
    check({tag, "/al6"}, {2'b00, d_out_al}, model(6, 1'b1, din, en));
    check({tag, "/ah6"}, {2'b00, d_out_ah}, model(6, 1'b0, din, en));
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input string tag, input int din, input bit en);
    @(negedge clk);
    d_in = 3'(din);
    e    = en;
    @(posedge clk);
    #1;
    check_all(tag, din, en);
  endtask

  initial begin
    int din;
    bit en;

    // 1. Reset with no clock edge yet
    rst  = 1'b1;
    d_in = 3'd5;
    e    = 1'b1;
    #1;
    check_all("reset", 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("first_edge", 5, 1'b1);

    // 2. Full sweep
    for (int i = 0; i < 8; i++) begin
      step("sweep", i, 1'b1);
      check("sweep_onehot", 8'($countones(d_out)), 8'd1);
    end

    // 3. Enable gating
    step("gate_on", 4, 1'b1);
    step("gate_off5", 5, 1'b0);
    step("gate_off6", 6, 1'b0);
    step("gate_reen", 6, 1'b1);

    // 4. Latency: change between edges must not reach the output
    step("lat_pre", 1, 1'b1);
    #1;
    d_in = 3'd2;
    #3;
    check_all("lat_hold", 1, 1'b1);
    @(posedge clk);
    #1;
    check_all("lat_update", 2, 1'b1);

    // 5. Mid-operation asynchronous reset
    step("mid_pre", 7, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all("mid_rst", 0, 1'b0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("mid_restore", 7, 1'b1);

    // 6. Narrow-output variants, in-range and out-of-range codes
    step("var_in", 2, 1'b1);
    step("var_oor", 7, 1'b1);
    step("var_oor6", 6, 1'b1);

    // Randomized run with occasional reset pulses between edges
    for (int i = 0; i < 300; i++) begin
      din = int'($urandom_range(0, 7));
      en  = ($urandom_range(0, 3) != 0);
      step("rand", din, en);
      if (en) check("rand_onehot", 8'($countones(d_out)), 8'd1);
      else    check("rand_zero_cnt", 8'($countones(d_out)), 8'd0);
      if ($urandom_range(0, 19) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        check_all("rand_rst", 0, 1'b0);
        rst = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_3_to_8.md
Name: dec_3_to_8

Overview:
Registered binary-to-one-hot decoder with an enable input. The default configuration decodes a 3-bit select into an 8-bit one-hot word. It drives chip-select and row-select style fan-out in datapath and control logic. The output is registered on the single system clock and cleared by an asynchronous active-high reset.

Parameters:
IN_W, 3, width of the binary select input d_in; legal range 1..6.
OUT_W, 8, width of d_out; must satisfy 1 <= OUT_W <= 2**IN_W; default is 2**IN_W.
ACTIVE_LOW, 0, output polarity. 0 means the selected bit is 1 and all others are 0. 1 means the whole output word is inverted: selected bit is 0, others are 1.

Ports:
clk    input   1      system clock; all state updates on the rising edge.
rst    input   1      reset; asynchronous, active-high.
d_in   input   IN_W   binary select code, unsigned.
e      input   1      decode enable, active-high.
d_out  output  OUT_W  registered one-hot (or one-cold) decode result.

Behaviour:
- Clocking and reset: one clock and one reset. Reset is asynchronous and active-high.
- While rst=1:
  - ACTIVE_LOW=0: d_out = all zeros.
  - ACTIVE_LOW=1: d_out = all ones (the inactive value).
  - The reset takes effect immediately, with no clock edge required.
  - Release of rst is sampled synchronously; the first decode update is on the first rising clk edge after rst falls.
- Decode function, evaluated from d_in and e sampled at the rising edge:
  - e=1 and d_in < OUT_W: next bit k of d_out is 1 when k == d_in, otherwise 0. Equivalently d_out = 1 << d_in.
  - e=1 and d_in >= OUT_W (only possible when OUT_W < 2**IN_W): next d_out = all zeros. No bit is selected; there is no error flag.
  - e=0: next d_out = all zeros, regardless of d_in.
  - ACTIVE_LOW=1: the result above is bitwise inverted before it is registered.
- Latency: exactly 1 clock cycle from input change to output update. d_out is a pure register output with no combinational path from d_in or e.
- Throughput: a new code is accepted every cycle; no handshake or backpressure.
- Invariant (ACTIVE_LOW=0): d_out always has at most one bit set. Exactly one bit is set when e=1 and d_in < OUT_W.
- Disabling: when e drops, d_out goes to zero on the next edge. When e rises, the decode of the current d_in appears on the next edge.
- Reset mid-operation: asserting rst between edges forces d_out to the inactive value immediately. The value held before reset is discarded.
- X/unknown inputs are not handled specially. Inputs are expected to be driven to known values whenever rst=0.
- Arithmetic: d_in is unsigned. Index comparison uses the full IN_W bits with no truncation or wrap-around.

Test Plan:
1. Reset: assert rst=1 with d_in=3'd5, e=1, no clock edge -> d_out=8'h00 immediately. Release rst; after the first rising edge -> d_out=8'h20.
2. Full sweep: e=1, d_in stepping 0..7 one value per cycle -> one cycle later d_out = 1, 2, 4, 8, 16, 32, 64, 128 (decimal). Each output has exactly one bit set.
3. Enable gating: e=1 with d_in=4 -> d_out=16. Then d_in=5 and 6 with e=0 -> d_out=0 on each following edge. Re-assert e=1 with d_in=6 -> d_out=64 one cycle later.
4. Latency check: change d_in from 1 to 2 just after an edge -> d_out stays 8'h02 until the next rising edge, then becomes 8'h04. No change occurs between edges.
5. Mid-operation reset: with d_out=8'h80 (d_in=7, e=1), pulse rst between edges -> d_out=8'h00 asynchronously. After release, the next edge restores 8'h80.
6. Parameter variants:
   - IN_W=3, OUT_W=6, ACTIVE_LOW=1: reset -> 6'h3F. d_in=2, e=1 -> 6'b111011. d_in=7, e=1 -> 6'h3F.
   - IN_W=3, OUT_W=6, ACTIVE_LOW=0: d_in=7, e=1 -> 6'h00.
